// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: default widths, the zero-register index
// and the address-validity helper used by the register file and scoreboard.
package mips_pkg;

    localparam int          DATA_W_DEF = 32;
    localparam int          ADDR_W_DEF = 5;
    localparam int unsigned REG_ZERO   = 0;

    // An address is usable when it names an implemented register and is not
    // the hardwired-zero register.
    function automatic logic valid_addr(input int unsigned addr,
                                        input int unsigned num_regs,
                                        input logic        zero_reg);
        return (addr < num_regs) && !(zero_reg && (addr == REG_ZERO));
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback-side bus of the register file: two read ports, the
// writeback port and the issue request with its stall answer.
interface reg_file_sb_if
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic [ADDR_W-1:0] read_1;
    logic [ADDR_W-1:0] read_2;
    logic [DATA_W-1:0] read_dat_1;
    logic [DATA_W-1:0] read_dat_2;
    logic              busy_1;
    logic              busy_2;
    logic              regwrite;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_reg;
    logic              issue_stall;

    modport master (
        output read_1, read_2, regwrite, write_reg, write_data,
               issue_valid, issue_reg,
        input  read_dat_1, read_dat_2, busy_1, busy_2, issue_stall
    );

    modport slave (
        input  read_1, read_2, regwrite, write_reg, write_data,
               issue_valid, issue_reg,
        output read_dat_1, read_dat_2, busy_1, busy_2, issue_stall
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Write-pending scoreboard: one busy bit per register, set on accepted issue,
// cleared on writeback, and the RAW/WAW hazard outputs derived from it.
module rf_scoreboard
    import mips_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_1_i,
    input  logic [ADDR_W-1:0] read_2_i,
    input  logic              regwrite_i,
    input  logic [ADDR_W-1:0] write_reg_i,
    input  logic              issue_valid_i,
    input  logic [ADDR_W-1:0] issue_reg_i,
    output logic              busy_1_o,
    output logic              busy_2_o,
    output logic              issue_stall_o
);
    localparam logic ZERO_EN = (ZERO_REG != 0);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                wr_valid;
    logic                iss_valid;
    logic                issue_accept;
    logic                busy_rd1;
    logic                busy_rd2;
    logic                busy_iss;

    assign wr_valid  = regwrite_i && valid_addr(32'(write_reg_i), NUM_REGS, ZERO_EN);
    assign iss_valid = valid_addr(32'(issue_reg_i), NUM_REGS, ZERO_EN);

    // Look up the busy bit behind each address; unimplemented addresses read
    // as not busy, and the zero register is never set so it reads 0 as well.
    always_comb begin
        busy_rd1 = 1'b0;
        busy_rd2 = 1'b0;
        busy_iss = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (read_1_i == ADDR_W'(i))    busy_rd1 = busy_q[i];
            if (read_2_i == ADDR_W'(i))    busy_rd2 = busy_q[i];
            if (issue_reg_i == ADDR_W'(i)) busy_iss = busy_q[i];
        end
    end

    // A writeback in the same cycle satisfies the hazard together with the
    // data bypass, so it masks both the read busy flags and the issue stall.
    always_comb begin
        busy_1_o      = busy_rd1 && !(regwrite_i && (write_reg_i == read_1_i));
        busy_2_o      = busy_rd2 && !(regwrite_i && (write_reg_i == read_2_i));
        issue_stall_o = issue_valid_i && busy_iss &&
                        !(regwrite_i && (write_reg_i == issue_reg_i));
        issue_accept  = issue_valid_i && !issue_stall_o && iss_valid;
    end

    // Next busy vector: clear on writeback first, then set on issue so a newer
    // issue to the same register wins over the older instruction's writeback.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_valid && (write_reg_i == ADDR_W'(i)))     busy_d[i] = 1'b0;
            if (issue_accept && (issue_reg_i == ADDR_W'(i))) busy_d[i] = 1'b1;
        end
        if (ZERO_EN) busy_d[REG_ZERO] = 1'b0;
    end

    // Busy state register; reset drops every pending write.
    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

endmodule

// File: rtl/reg_file_sb.sv
// MIPS decode-stage register file: edge-triggered storage, two combinational
// read ports with writeback bypass, optional hardwired r0 and a scoreboard.
module reg_file_sb
    import mips_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1
) (
    input logic         clk,
    input logic         rst,
    reg_file_sb_if.slave bus
);
    localparam logic ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wr_valid;
    logic              rd1_valid;
    logic              rd2_valid;

    assign wr_valid  = bus.regwrite && valid_addr(32'(bus.write_reg), NUM_REGS, ZERO_EN);
    assign rd1_valid = valid_addr(32'(bus.read_1), NUM_REGS, ZERO_EN);
    assign rd2_valid = valid_addr(32'(bus.read_2), NUM_REGS, ZERO_EN);

    // Next storage contents: only a valid writeback address changes anything.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_valid && (bus.write_reg == ADDR_W'(i))) regs_d[i] = bus.write_data;
        end
    end

    // Register array; reset clears every entry and discards that cycle's write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read muxes: invalid addresses read 0, a same-cycle writeback bypasses
    // the array so decode sees the value before it is stored.
    always_comb begin
        bus.read_dat_1 = '0;
        bus.read_dat_2 = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.read_1 == ADDR_W'(i)) bus.read_dat_1 = regs_q[i];
            if (bus.read_2 == ADDR_W'(i)) bus.read_dat_2 = regs_q[i];
        end
        if (wr_valid && (bus.write_reg == bus.read_1)) bus.read_dat_1 = bus.write_data;
        if (wr_valid && (bus.write_reg == bus.read_2)) bus.read_dat_2 = bus.write_data;
        if (!rd1_valid) bus.read_dat_1 = '0;
        if (!rd2_valid) bus.read_dat_2 = '0;
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .read_1_i      (bus.read_1),
        .read_2_i      (bus.read_2),
        .regwrite_i    (bus.regwrite),
        .write_reg_i   (bus.write_reg),
        .issue_valid_i (bus.issue_valid),
        .issue_reg_i   (bus.issue_reg),
        .busy_1_o      (bus.busy_1),
        .busy_2_o      (bus.busy_2),
        .issue_stall_o (bus.issue_stall)
    );

endmodule
